id_ex_pipe: RTL
===============

# id_ex_pipe

ID/EX pipeline stage of the five-stage MIPS core. It sits directly downstream of the instruction decoder. It registers the decoded control bundle and operand data into the EX stage and resolves the destination register index. It also detects load-use hazards, inserting a one-cycle bubble and stalling PC and IF/ID, and it applies branch/jump flushes and external hold requests.

## Interface
- `DW`, 32, datapath width
- `RW`, 5, register index width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a real instruction
- `id_pcsrc`, `id_regdst`, `id_memtoreg`  in  2 each  decoder control fields
- `id_branch`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_alusrc1`, `id_alusrc2`  in  1 each  decoder control bits
- `id_aluop`  in  4  decoder ALU opcode
- `id_pc4`, `id_rs_data`, `id_rt_data`, `id_imm`  in  DW each  PC+4, register-file reads, extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  RW each  register indices
- `id_shamt`  in  5  shift amount
- `id_funct`  in  6  function field
- `flush_in`  in  1  branch taken or jump resolved; kill ID instruction
- `stall_in`  in  1  downstream hold; freeze stage
- `ex_*`  out  same widths as the `id_*` inputs  registered copies of every `id_*` field above
- `ex_valid`  out  1  EX holds a real instruction
- `ex_wreg`  out  RW  resolved write index: RegDst 00→rt, 01→rd, 10→31, 11→0
- `id_stall`  out  1  hold PC and IF/ID this cycle
- `bubble_cnt`  out  32  count of inserted bubbles

## Operation
- Hazard (combinational) requires all of the following:
  - `ex_valid`, `ex_memread` and `ex_wreg != 0`
  - `id_valid`
  - `ex_wreg == id_rs`, or (`ex_wreg == id_rt` and `id_alusrc2 == 0`, or `id_memwrite`)
- Per-edge update, in priority order:
  1. reset low: all `ex_*` outputs 0, `ex_valid` 0, `ex_wreg` 0, `bubble_cnt` 0.
  2. `flush_in`: `ex_valid` 0. All control outputs (`ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch`, `ex_pcsrc`) 0. Data fields are don't-care and are loaded normally.
  3. `stall_in`: all registers hold.
  4. hazard: insert a bubble. Behaves as flush for control and `ex_valid`. `bubble_cnt` increments, saturating at 0xFFFFFFFF.
  5. otherwise: load all `id_*` fields. `ex_valid` ← `id_valid`. `ex_wreg` ← resolved index.
- `id_stall = stall_in | (hazard & ~flush_in)`.
- Invalid ID (`id_valid` 0) loads with control bits zeroed, so no architectural side effects reach EX.
- Writes targeting register 0 never trigger a hazard.

## Timing
- Latency: one cycle, ID→EX.
- `id_stall` is combinational from the current EX registers and the ID inputs, with no registered delay.
- A load-use hazard produces exactly one bubble. On the next cycle the load has moved to MEM, the hazard clears, and the stalled instruction loads.
- Flush and hazard in the same cycle: flush wins, `id_stall` 0, and the counter does not increment.
- Flush and `stall_in` in the same cycle: flush wins, and `id_stall` is 1 because of `stall_in`.
- `stall_in` during a hazard: hold, with no counter increment.
- Reset asserted mid-operation: outputs clear immediately, asynchronously. Operation resumes on the first edge after deassertion.

## Configuration
- `ID_EX_LOADUSE_EN`
  - Defined: hazard detection, bubble insertion and `bubble_cnt` are active as above.
  - Undefined: hazard is constant 0, `id_stall = stall_in`, and `bubble_cnt` is tied to 0. Software must schedule NOPs after loads.

## Structure
- Shared package `mips_pkg`:
  - RegDst encodings (`REGDST_RT`, `REGDST_RD`, `REGDST_RA`)
  - MemtoReg and PCSrc encodings
  - `REG_RA = 31`
  - packed `ctrl_t` struct of the control bundle, with the zero constant `CTRL_NOP`
- Sub-module `hazard_detect`: combinational load-use comparator producing `hazard`. It is instantiated only under `ID_EX_LOADUSE_EN`.

## Test plan
- Normal load: `add $3,$1,$2` (RegDst 01, rd=3) with `id_valid` 1 → next edge `ex_wreg`=3, `ex_regwrite`=1, `ex_valid`=1.
- Load-use, rs match: `lw $5,0($1)` in EX, then `add $6,$5,$2` in ID → `id_stall` 1 for one cycle, bubble with `ex_regwrite` 0, `bubble_cnt` 1. The add reaches EX one cycle later.
- Load with destination $0: `lw $0` followed by a consumer of $0 → no stall, `bubble_cnt` stays 0.
- Flush plus hazard in the same cycle → `ex_valid` 0, `id_stall` 0, `bubble_cnt` unchanged.
- `stall_in` held high for 3 cycles → all `ex_*` outputs stable and `id_stall` 1 throughout.
- `jal` (RegDst 10): `ex_wreg`=31. Reset pulsed mid-stream → all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: encodings and the decoded control bundle shared by the MIPS
// pipeline stages.
//   regdst_e   - destination-register select (rt, rd, $ra, $0)
//   memtoreg_e - write-back source select
//   pcsrc_e    - next-PC source select
//   ctrl_t     - packed decoder control bundle, CTRL_NOP is its all-zero value
//   squashCtrl - clears the bits that cause architectural side effects
package mips_pkg;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_RA   = 2'b10,
    REGDST_ZERO = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    MEMTOREG_ALU = 2'b00,
    MEMTOREG_MEM = 2'b01,
    MEMTOREG_PC4 = 2'b10
  } memtoreg_e;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pcsrc_e;

  // Link register written by jal.
  localparam int unsigned REG_RA = 31;

  typedef struct packed {
    logic [1:0] pcSrc;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       branch;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc1;
    logic       aluSrc2;
    logic [3:0] aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // A squashed instruction keeps its operand-select fields but can no longer
  // write a register, touch memory or redirect the PC.
  function automatic ctrl_t squashCtrl(input ctrl_t c);
    ctrl_t s;
    s          = c;
    s.pcSrc    = PCSRC_SEQ;
    s.branch   = 1'b0;
    s.regWrite = 1'b0;
    s.memRead  = 1'b0;
    s.memWrite = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator for the ID/EX stage.
// Ports:
//   exValid, exMemRead, exWreg - the instruction currently in EX
//   idValid, idRs, idRt        - the instruction currently in ID
//   idAluSrc2, idMemWrite      - whether ID actually reads rt
//   hazard                     - ID consumes the register EX is loading
module hazard_detect #(
  parameter int RW = 5
) (
  input  logic          exValid,
  input  logic          exMemRead,
  input  logic [RW-1:0] exWreg,
  input  logic          idValid,
  input  logic [RW-1:0] idRs,
  input  logic [RW-1:0] idRt,
  input  logic          idAluSrc2,
  input  logic          idMemWrite,
  output logic          hazard
);

  logic exLoad;
  logic rsUse;
  logic rtUse;

  // $0 is hardwired, so a load into it has no consumer to protect.
  assign exLoad = exValid & exMemRead & (exWreg != '0);
  assign rsUse  = (exWreg == idRs);
  // rt is a source for R-type ALU ops and is the store data for sw.
  assign rtUse  = (exWreg == idRt) & (~idAluSrc2 | idMemWrite);
  assign hazard = exLoad & idValid & (rsUse | rtUse);

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register of the five-stage MIPS core.
// Registers the decoded control bundle and operands into EX, resolves the
// destination register, applies flushes and downstream holds, and (when
// ID_EX_LOADUSE_EN is defined) inserts one bubble per load-use hazard.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   id_*                  - decoded instruction fields from ID
//   flush_in              - kill the instruction in ID (taken branch/jump)
//   stall_in              - downstream hold, freeze this stage
//   ex_*                  - registered copies of the id_* fields
//   ex_valid, ex_wreg     - EX holds a real instruction, resolved write index
//   id_stall              - hold PC and IF/ID this cycle
//   bubble_cnt            - saturating count of inserted bubbles
// Macro ID_EX_LOADUSE_EN: enables hazard detection and bubble_cnt; when
// undefined the hazard is constant 0 and bubble_cnt is tied to 0.
module id_ex_pipe
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [1:0]    id_pcsrc,
  input  logic [1:0]    id_regdst,
  input  logic [1:0]    id_memtoreg,
  input  logic          id_branch,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_alusrc1,
  input  logic          id_alusrc2,
  input  logic [3:0]    id_aluop,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_funct,
  input  logic          flush_in,
  input  logic          stall_in,
  output logic [1:0]    ex_pcsrc,
  output logic [1:0]    ex_regdst,
  output logic [1:0]    ex_memtoreg,
  output logic          ex_branch,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_alusrc1,
  output logic          ex_alusrc2,
  output logic [3:0]    ex_aluop,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [4:0]    ex_shamt,
  output logic [5:0]    ex_funct,
  output logic          ex_valid,
  output logic [RW-1:0] ex_wreg,
  output logic          id_stall,
  output logic [31:0]   bubble_cnt
);

  ctrl_t         idCtrl;
  ctrl_t         nextCtrl;
  ctrl_t         exCtrl;
  logic          hazard;
  logic          kill;
  logic          loadEn;
  logic [RW-1:0] wregNext;

  logic          validQ;
  logic [RW-1:0] wregQ;
  logic [DW-1:0] pc4Q;
  logic [DW-1:0] rsDataQ;
  logic [DW-1:0] rtDataQ;
  logic [DW-1:0] immQ;
  logic [RW-1:0] rsQ;
  logic [RW-1:0] rtQ;
  logic [RW-1:0] rdQ;
  logic [4:0]    shamtQ;
  logic [5:0]    functQ;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // fall through and infer a latch.
    idCtrl          = CTRL_NOP;
    idCtrl.pcSrc    = id_pcsrc;
    idCtrl.regDst   = id_regdst;
    idCtrl.memToReg = id_memtoreg;
    idCtrl.branch   = id_branch;
    idCtrl.regWrite = id_regwrite;
    idCtrl.memRead  = id_memread;
    idCtrl.memWrite = id_memwrite;
    idCtrl.aluSrc1  = id_alusrc1;
    idCtrl.aluSrc2  = id_alusrc2;
    idCtrl.aluOp    = id_aluop;
  end

  always_comb begin
    wregNext = '0;
    case (regdst_e'(id_regdst))
      REGDST_RT:   wregNext = id_rt;
      REGDST_RD:   wregNext = id_rd;
      REGDST_RA:   wregNext = RW'(REG_RA);
      REGDST_ZERO: wregNext = '0;
      default:     wregNext = '0;
    endcase
  end

`ifdef ID_EX_LOADUSE_EN
  logic [31:0] bubbleQ;

  hazard_detect #(.RW(RW)) u_hazard (
    .exValid    (validQ),
    .exMemRead  (exCtrl.memRead),
    .exWreg     (wregQ),
    .idValid    (id_valid),
    .idRs       (id_rs),
    .idRt       (id_rt),
    .idAluSrc2  (id_alusrc2),
    .idMemWrite (id_memwrite),
    .hazard     (hazard)
  );

  // A bubble only counts when it is actually written: flush overrides it and
  // a downstream hold postpones it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbleQ <= '0;
    end else if (hazard && !flush_in && !stall_in && (bubbleQ != '1)) begin
      bubbleQ <= bubbleQ + 32'd1;
    end
  end

  assign bubble_cnt = bubbleQ;
`else
  assign hazard     = 1'b0;
  assign bubble_cnt = '0;
`endif

  // Flushes, bubbles and invalid slots all enter EX with side effects removed.
  assign kill     = flush_in | hazard | ~id_valid;
  assign nextCtrl = kill ? squashCtrl(idCtrl) : idCtrl;
  // A flush must still land even while downstream is holding.
  assign loadEn   = flush_in | ~stall_in;
  assign id_stall = stall_in | (hazard & ~flush_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exCtrl  <= CTRL_NOP;
      validQ  <= 1'b0;
      wregQ   <= '0;
      pc4Q    <= '0;
      rsDataQ <= '0;
      rtDataQ <= '0;
      immQ    <= '0;
      rsQ     <= '0;
      rtQ     <= '0;
      rdQ     <= '0;
      shamtQ  <= '0;
      functQ  <= '0;
    end else if (loadEn) begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before the edge, regardless of statement order.
      exCtrl  <= nextCtrl;
      validQ  <= id_valid & ~flush_in & ~hazard;
      wregQ   <= wregNext;
      pc4Q    <= id_pc4;
      rsDataQ <= id_rs_data;
      rtDataQ <= id_rt_data;
      immQ    <= id_imm;
      rsQ     <= id_rs;
      rtQ     <= id_rt;
      rdQ     <= id_rd;
      shamtQ  <= id_shamt;
      functQ  <= id_funct;
    end
  end

  assign ex_pcsrc    = exCtrl.pcSrc;
  assign ex_regdst   = exCtrl.regDst;
  assign ex_memtoreg = exCtrl.memToReg;
  assign ex_branch   = exCtrl.branch;
  assign ex_regwrite = exCtrl.regWrite;
  assign ex_memread  = exCtrl.memRead;
  assign ex_memwrite = exCtrl.memWrite;
  assign ex_alusrc1  = exCtrl.aluSrc1;
  assign ex_alusrc2  = exCtrl.aluSrc2;
  assign ex_aluop    = exCtrl.aluOp;
  assign ex_valid    = validQ;
  assign ex_wreg     = wregQ;
  assign ex_pc4      = pc4Q;
  assign ex_rs_data  = rsDataQ;
  assign ex_rt_data  = rtDataQ;
  assign ex_imm      = immQ;
  assign ex_rs       = rsQ;
  assign ex_rt       = rtQ;
  assign ex_rd       = rdQ;
  assign ex_shamt    = shamtQ;
  assign ex_funct    = functQ;

endmodule
